// File: rtl/mult_div_seq.sv
// Iterative signed multiply/divide unit: radix-2 Booth MULT and restoring DIV,
// one bit per clock, with a final sign-fix cycle that commits hi/lo.
module mult_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CW      = $clog2(WIDTH + 1);
    localparam logic [1:0]  OP_MULT = 2'b01;
    localparam logic [1:0]  OP_DIV  = 2'b10;

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             acc_q;
    logic [WIDTH-1:0] operand;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_part;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Booth add/sub is done one bit wider so that subtracting the most
    // negative multiplicand cannot overflow before the arithmetic shift.
    always_comb begin
        booth_sum = {acc_hi[WIDTH-1], acc_hi};
        case ({acc_lo[0], acc_q})
            2'b01:   booth_sum = {acc_hi[WIDTH-1], acc_hi} + {operand[WIDTH-1], operand};
            2'b10:   booth_sum = {acc_hi[WIDTH-1], acc_hi} - {operand[WIDTH-1], operand};
            default: booth_sum = {acc_hi[WIDTH-1], acc_hi};
        endcase
    end

    always_comb begin
        div_part = {acc_hi, acc_lo[WIDTH-1]};
        div_ge   = (div_part >= {1'b0, operand});
        div_diff = div_part[WIDTH-1:0] - operand;
        a_mag    = a[WIDTH-1] ? -a : a;
        b_mag    = b[WIDTH-1] ? -b : b;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            acc_q    <= 1'b0;
            operand  <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (op == OP_MULT) begin
                        acc_hi   <= '0;
                        acc_lo   <= b;
                        acc_q    <= 1'b0;
                        operand  <= a;
                        is_div   <= 1'b0;
                        div_zero <= 1'b0;
                        busy     <= 1'b1;
                        count    <= CW'(WIDTH);
                        state    <= MUL_RUN;
                    end else if (op == OP_DIV) begin
                        if (b == '0) begin
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            acc_hi   <= '0;
                            acc_lo   <= a_mag;
                            acc_q    <= 1'b0;
                            operand  <= b_mag;
                            neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r    <= a[WIDTH-1];
                            is_div   <= 1'b1;
                            div_zero <= 1'b0;
                            busy     <= 1'b1;
                            count    <= CW'(WIDTH);
                            state    <= DIV_RUN;
                        end
                    end
                end
                MUL_RUN: begin
                    acc_hi <= booth_sum[WIDTH:1];
                    acc_lo <= {booth_sum[0], acc_lo[WIDTH-1:1]};
                    acc_q  <= acc_lo[0];
                    count  <= count - CW'(1);
                    if (count == CW'(1))
                        state <= FIX;
                end
                DIV_RUN: begin
                    acc_hi <= div_ge ? div_diff : div_part[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    count  <= count - CW'(1);
                    if (count == CW'(1))
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        lo <= neg_q ? -acc_lo : acc_lo;
                        hi <= neg_r ? -acc_hi : acc_hi;
                    end else begin
                        lo <= acc_lo;
                        hi <= acc_hi;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed self-checking bench for mult_div_seq: products, quotients, latency,
// divide-by-zero, op-ignore while busy, async reset abort and back-to-back ops.
module tb_mult_div_seq;

    localparam int unsigned WIDTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .op       (op),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    // Drive op for exactly the accept edge, then scramble operands; returns at E0+1.
    task automatic start_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        op = o;
        a  = va;
        b  = vb;
        @(posedge clk);
        #1;
        op = 2'b00;
        a  = $urandom;
        b  = $urandom;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        n_checks++; if (hi !== 32'h0)    begin n_fail++; $display("FAIL reset_hi: got %h expected %h", hi, 32'h0); end
        n_checks++; if (lo !== 32'h0)    begin n_fail++; $display("FAIL reset_lo: got %h expected %h", lo, 32'h0); end
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
    endtask

    task automatic test_mult();
        int edges;
        int busy_err;
        start_op(2'b01, 32'd7, 32'hFFFF_FFFD);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_accept: got %b expected 1", busy); end
        edges = 0;
        busy_err = 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges < 33 && busy !== 1'b1) busy_err++;
        end
        n_checks++; if (edges != 33)     begin n_fail++; $display("FAIL mult_latency: got %0d expected 33", edges); end
        n_checks++; if (busy_err != 0)   begin n_fail++; $display("FAIL mult_busy_run: got %0d low cycles expected 0", busy_err); end
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL mult_busy_done: got %b expected 0", busy); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
        n_checks++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo: got %h expected %h", lo, 32'hFFFF_FFEB); end
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_mult_corner();
        int edges;
        start_op(2'b01, 32'h8000_0000, 32'h8000_0000);
        wait_done(edges);
        n_checks++; if (edges != 33)          begin n_fail++; $display("FAIL mult_min_latency: got %0d expected 33", edges); end
        n_checks++; if (hi !== 32'h4000_0000) begin n_fail++; $display("FAIL mult_min_hi: got %h expected %h", hi, 32'h4000_0000); end
        n_checks++; if (lo !== 32'h0000_0000) begin n_fail++; $display("FAIL mult_min_lo: got %h expected %h", lo, 32'h0); end
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(edges);
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL mult_m1_hi: got %h expected %h", hi, 32'h0); end
        n_checks++; if (lo !== 32'h1) begin n_fail++; $display("FAIL mult_m1_lo: got %h expected %h", lo, 32'h1); end
    endtask

    task automatic test_div();
        int edges;
        start_op(2'b10, 32'd100, 32'd7);
        wait_done(edges);
        n_checks++; if (edges != 33)   begin n_fail++; $display("FAIL div_latency: got %0d expected 33", edges); end
        n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL div_pos_lo: got %h expected %h", lo, 32'd14); end
        n_checks++; if (hi !== 32'd2)  begin n_fail++; $display("FAIL div_pos_hi: got %h expected %h", hi, 32'd2); end
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(edges);
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h expected %h", lo, 32'hFFFF_FFFD); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(edges);
        n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected %h", lo, 32'h8000_0000); end
        n_checks++; if (hi !== 32'h0)         begin n_fail++; $display("FAIL div_ovf_hi: got %h expected %h", hi, 32'h0); end
        n_checks++; if (div_zero !== 1'b0)    begin n_fail++; $display("FAIL div_ovf_dz: got %b expected 0", div_zero); end
    endtask

    task automatic test_div_zero();
        int edges;
        start_op(2'b01, 32'h1234, 32'h10);
        wait_done(edges);
        n_checks++; if (lo !== 32'h0001_2340) begin n_fail++; $display("FAIL dz_prior_lo: got %h expected %h", lo, 32'h0001_2340); end
        start_op(2'b10, 32'd5, 32'd0);
        n_checks++; if (done !== 1'b1)        begin n_fail++; $display("FAIL dz_done: got %b expected 1", done); end
        n_checks++; if (div_zero !== 1'b1)    begin n_fail++; $display("FAIL dz_flag: got %b expected 1", div_zero); end
        n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL dz_busy: got %b expected 0", busy); end
        n_checks++; if (hi !== 32'h0)         begin n_fail++; $display("FAIL dz_hi_kept: got %h expected %h", hi, 32'h0); end
        n_checks++; if (lo !== 32'h0001_2340) begin n_fail++; $display("FAIL dz_lo_kept: got %h expected %h", lo, 32'h0001_2340); end
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0)        begin n_fail++; $display("FAIL dz_done_pulse: got %b expected 0", done); end
        n_checks++; if (div_zero !== 1'b1)    begin n_fail++; $display("FAIL dz_flag_hold: got %b expected 1", div_zero); end
        n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL dz_busy_after: got %b expected 0", busy); end
        start_op(2'b01, 32'd3, 32'd5);
        n_checks++; if (div_zero !== 1'b0)    begin n_fail++; $display("FAIL dz_clear: got %b expected 0", div_zero); end
        n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL dz_next_busy: got %b expected 1", busy); end
        wait_done(edges);
        n_checks++; if (lo !== 32'd15)        begin n_fail++; $display("FAIL dz_next_lo: got %h expected %h", lo, 32'd15); end
    endtask

    task automatic test_op_ignore();
        int edges;
        int pulses;
        int busy_seen;
        start_op(2'b01, 32'd5, 32'd6);
        repeat (4) @(posedge clk);
        @(negedge clk);
        op = 2'b10;
        a  = 32'd100;
        b  = 32'd7;
        edges = 4;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        op = 2'b00;
        n_checks++; if (edges != 33)   begin n_fail++; $display("FAIL ign_latency: got %0d expected 33", edges); end
        n_checks++; if (lo !== 32'd30) begin n_fail++; $display("FAIL ign_lo: got %h expected %h", lo, 32'd30); end
        n_checks++; if (hi !== 32'd0)  begin n_fail++; $display("FAIL ign_hi: got %h expected %h", hi, 32'd0); end
        pulses = 0;
        busy_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
            if (busy) busy_seen++;
        end
        n_checks++; if (pulses != 0)    begin n_fail++; $display("FAIL ign_extra_done: got %0d expected 0", pulses); end
        n_checks++; if (busy_seen != 0) begin n_fail++; $display("FAIL ign_div_started: got %0d busy cycles expected 0", busy_seen); end
    endtask

    task automatic test_reset_mid();
        int edges;
        int pulses;
        start_op(2'b10, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (hi !== 32'h0)      begin n_fail++; $display("FAIL rst_mid_hi: got %h expected %h", hi, 32'h0); end
        n_checks++; if (lo !== 32'h0)      begin n_fail++; $display("FAIL rst_mid_lo: got %h expected %h", lo, 32'h0); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", done); end
        n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dz: got %b expected 0", div_zero); end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d expected 0", pulses); end
        start_op(2'b01, 32'd3, 32'd4);
        wait_done(edges);
        n_checks++; if (lo !== 32'd12) begin n_fail++; $display("FAIL rst_next_lo: got %h expected %h", lo, 32'd12); end
        n_checks++; if (hi !== 32'd0)  begin n_fail++; $display("FAIL rst_next_hi: got %h expected %h", hi, 32'd0); end
    endtask

    task automatic test_back_to_back();
        int edges;
        int first;
        int second;
        @(negedge clk);
        op = 2'b01;
        a  = 32'd2;
        b  = 32'd3;
        @(posedge clk);
        #1;
        edges  = 0;
        first  = -1;
        second = -1;
        while (second < 0 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) begin
                if (first < 0) first = edges;
                else second = edges;
            end
        end
        op = 2'b00;
        n_checks++; if (first != 33)   begin n_fail++; $display("FAIL b2b_first: got %0d expected 33", first); end
        n_checks++; if (second != 67)  begin n_fail++; $display("FAIL b2b_second: got %0d expected 67", second); end
        n_checks++; if (lo !== 32'd6)  begin n_fail++; $display("FAIL b2b_lo: got %h expected %h", lo, 32'd6); end
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_done: got %b expected 0", done); end
    endtask

    initial begin
        reset = 1'b1;
        op    = 2'b00;
        a     = 32'h0;
        b     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_mult();
        test_mult_corner();
        test_div();
        test_div_zero();
        test_op_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
